// File: rtl/px_adc_capture_multi.sv
// Multi-channel serial ADC capture engine: drives shared CS/SCLK, shifts NUM_CH
// data lines in parallel, optionally averages 2^AVG_LOG2 conversions per start.
module px_adc_capture_multi #(
    parameter int NUM_CH     = 2,
    parameter int ADC_BITS   = 12,
    parameter int FRAME_BITS = 16,
    parameter int LEAD_BITS  = 4,
    parameter int CLK_DIV    = 2,
    parameter int QUIET      = 4,
    parameter int AVG_LOG2   = 0
) (
    input  logic                         CLK50,
    input  logic                         MSS_RESET_N,
    input  logic                         start_capture,
    input  logic [NUM_CH-1:0]            adc_din,
    output logic                         CS,
    output logic                         SCLK,
    output logic                         busy,
    output logic                         adc_conv_complete,
    output logic [NUM_CH*ADC_BITS-1:0]   data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int CNT_MAX = (2 * CLK_DIV > QUIET) ? 2 * CLK_DIV : QUIET;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(FRAME_BITS + 1);
    localparam int VW      = AVG_LOG2 + 1;
    localparam int AW      = ADC_BITS + AVG_LOG2;

    localparam logic [CW-1:0] SETUP_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] RISE_CNT    = CW'(CLK_DIV);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] QUIET_LAST  = CW'(QUIET - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] WIN_LO      = BW'(LEAD_BITS);
    localparam logic [BW-1:0] WIN_HI      = BW'(LEAD_BITS + ADC_BITS);
    localparam logic [VW-1:0] CONV_LAST   = VW'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_QUIET,
        S_LOAD
    } state_t;

    state_t                       r_state, w_state_next;
    logic [CW-1:0]                r_cnt, w_cnt_next;
    logic [BW-1:0]                r_bit, w_bit_next;
    logic [VW-1:0]                r_conv, w_conv_next;
    logic                         r_cs, r_sclk, r_valid, r_cc, r_overrun;
    logic [NUM_CH*ADC_BITS-1:0]   r_data;
    logic [NUM_CH*ADC_BITS-1:0]   w_avg;
    logic                         w_sample, w_acc_clr, w_acc_add, w_load_ok;
    logic                         w_cs_next, w_sclk_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_bit_next   = r_bit;
        w_conv_next  = r_conv;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (start_capture) begin
                    w_state_next = S_SETUP;
                    w_conv_next  = '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                end
            end
            S_SHIFT: begin
                if (r_cnt == PERIOD_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == BIT_LAST) w_state_next = S_QUIET;
                    else                   w_bit_next   = r_bit + 1'b1;
                end
            end
            S_QUIET: begin
                if (r_cnt == QUIET_LAST) begin
                    w_cnt_next = '0;
                    if (r_conv == CONV_LAST) begin
                        w_state_next = S_LOAD;
                    end else begin
                        w_state_next = S_SETUP;
                        w_conv_next  = r_conv + 1'b1;
                    end
                end
            end
            S_LOAD: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // CS/SCLK are registered from the next state so the ADC sees glitch-free pins.
    assign w_cs_next   = !((w_state_next == S_SETUP) || (w_state_next == S_SHIFT));
    assign w_sclk_next = !((w_state_next == S_SHIFT) && (w_cnt_next < RISE_CNT));

    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_conv  <= '0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_conv  <= w_conv_next;
            r_cs    <= w_cs_next;
            r_sclk  <= w_sclk_next;
        end
    end

    // Sample on the cycle SCLK is first high; only the result window is kept.
    assign w_sample  = (r_state == S_SHIFT) && (r_cnt == RISE_CNT) &&
                       (r_bit >= WIN_LO) && (r_bit < WIN_HI);
    assign w_acc_clr = (r_state == S_IDLE) && start_capture;
    assign w_acc_add = (r_state == S_QUIET) && (r_cnt == '0);
    assign w_load_ok = (r_state == S_LOAD) && (!r_valid || data_ready);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ADC_BITS-1:0] r_shift;
            logic [AW-1:0]       r_acc;

            always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
                if (!MSS_RESET_N) begin
                    r_shift <= '0;
                    r_acc   <= '0;
                end else begin
                    if (w_sample) r_shift <= {r_shift[ADC_BITS-2:0], adc_din[gi]};
                    if (w_acc_clr)      r_acc <= '0;
                    else if (w_acc_add) r_acc <= r_acc + AW'(r_shift);
                end
            end

            assign w_avg[gi*ADC_BITS +: ADC_BITS] = r_acc[AVG_LOG2 +: ADC_BITS];
        end
    endgenerate

    always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_cc      <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cc <= w_load_ok;
            if (w_load_ok) begin
                r_data  <= w_avg;
                r_valid <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid <= 1'b0;
            end
            if ((r_state == S_LOAD) && !w_load_ok) r_overrun <= 1'b1;
            else if (overrun_clr)                  r_overrun <= 1'b0;
        end
    end

    assign CS                = r_cs;
    assign SCLK              = r_sclk;
    assign busy              = (r_state != S_IDLE);
    assign adc_conv_complete = r_cc;
    assign data_out          = r_data;
    assign data_valid        = r_valid;
    assign overrun           = r_overrun;

endmodule

// File: tb/tb_px_adc_capture_multi.sv
// Bench for px_adc_capture_multi: three configurations (default, 4x averaging,
// 4-channel fast SCLK) each driven by a behavioural serial ADC model.
module tb_px_adc_capture_multi;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT A: defaults ----------------
    logic        a_start, a_ready, a_ovr_clr;
    logic [1:0]  a_din;
    logic        a_cs, a_sclk, a_busy, a_cc, a_valid, a_ovr;
    logic [23:0] a_data;

    px_adc_capture_multi dut_a (
        .CLK50(clk), .MSS_RESET_N(rst_n), .start_capture(a_start), .adc_din(a_din),
        .CS(a_cs), .SCLK(a_sclk), .busy(a_busy), .adc_conv_complete(a_cc),
        .data_out(a_data), .data_valid(a_valid), .data_ready(a_ready),
        .overrun(a_ovr), .overrun_clr(a_ovr_clr)
    );

    // ---------------- DUT B: 4x averaging, one channel ----------------
    logic        b_start, b_ready, b_ovr_clr;
    logic [0:0]  b_din;
    logic        b_cs, b_sclk, b_busy, b_cc, b_valid, b_ovr;
    logic [11:0] b_data;

    px_adc_capture_multi #(.NUM_CH(1), .AVG_LOG2(2)) dut_b (
        .CLK50(clk), .MSS_RESET_N(rst_n), .start_capture(b_start), .adc_din(b_din),
        .CS(b_cs), .SCLK(b_sclk), .busy(b_busy), .adc_conv_complete(b_cc),
        .data_out(b_data), .data_valid(b_valid), .data_ready(b_ready),
        .overrun(b_ovr), .overrun_clr(b_ovr_clr)
    );

    // ---------------- DUT C: 4 channels, CLK_DIV=1, 14-bit frame ----------------
    logic        c_start, c_ready, c_ovr_clr;
    logic [3:0]  c_din;
    logic        c_cs, c_sclk, c_busy, c_cc, c_valid, c_ovr;
    logic [47:0] c_data;

    px_adc_capture_multi #(.NUM_CH(4), .CLK_DIV(1), .FRAME_BITS(14), .LEAD_BITS(2)) dut_c (
        .CLK50(clk), .MSS_RESET_N(rst_n), .start_capture(c_start), .adc_din(c_din),
        .CS(c_cs), .SCLK(c_sclk), .busy(c_busy), .adc_conv_complete(c_cc),
        .data_out(c_data), .data_valid(c_valid), .data_ready(c_ready),
        .overrun(c_ovr), .overrun_clr(c_ovr_clr)
    );

    // ---------------- ADC models: next bit driven on each SCLK fall ----------------
    logic [15:0] a_frame [2];
    logic [15:0] b_frame [4];
    logic [13:0] c_frame [4];
    int a_idx, b_idx, c_idx, b_conv;
    int a_falls, b_falls, c_falls, b_csfalls;
    int a_cslow, b_cslow, c_cslow;
    int a_ccn, b_ccn, c_ccn;

    always @(negedge a_cs) a_idx = 0;
    always @(negedge a_sclk) if (!a_cs) begin
        if (a_idx < 16) for (int c = 0; c < 2; c++) a_din[c] = a_frame[c][15 - a_idx];
        a_idx++;
        a_falls++;
    end

    always @(negedge b_cs) begin b_idx = 0; b_csfalls++; end
    always @(posedge b_cs) if (b_conv < 3) b_conv++;
    always @(negedge b_sclk) if (!b_cs) begin
        if (b_idx < 16) b_din[0] = b_frame[b_conv][15 - b_idx];
        b_idx++;
        b_falls++;
    end

    always @(negedge c_cs) c_idx = 0;
    always @(negedge c_sclk) if (!c_cs) begin
        if (c_idx < 14) for (int c = 0; c < 4; c++) c_din[c] = c_frame[c][13 - c_idx];
        c_idx++;
        c_falls++;
    end

    always @(negedge clk) begin
        if (!a_cs) a_cslow++;
        if (!b_cs) b_cslow++;
        if (!c_cs) c_cslow++;
    end
    always @(posedge clk) begin
        if (a_cc) a_ccn++;
        if (b_cc) b_ccn++;
        if (c_cc) c_ccn++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic valid_of(input int d);
        case (d)
            0:       return a_valid;
            1:       return b_valid;
            default: return c_valid;
        endcase
    endfunction

    // Returns at the negedge just after the accepting edge (latency count 0).
    task automatic do_start(input int d);
        @(negedge clk);
        case (d)
            0:       a_start = 1'b1;
            1:       b_start = 1'b1;
            default: c_start = 1'b1;
        endcase
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    endtask

    task automatic wait_valid(input int d, input int n0, output int n);
        n = n0;
        while (!valid_of(d) && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_counts();
        a_falls = 0; b_falls = 0; c_falls = 0; b_csfalls = 0;
        a_cslow = 0; b_cslow = 0; c_cslow = 0;
        a_ccn = 0; b_ccn = 0; c_ccn = 0;
        b_conv = 0;
    endtask

    task automatic drain_a(input string name);
        a_ready = 1'b1;
        @(negedge clk);
        check({name, " valid drops after ready"}, 64'(a_valid), 64'd0);
        a_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  lead;
        logic [11:0] ch0;
        logic [11:0] ch1;
        logic [23:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int   n;

        vecs[0] = '{lead: 4'h0, ch0: 12'hA5C, ch1: 12'h3F1, exp: 24'h3F1A5C};
        vecs[1] = '{lead: 4'hF, ch0: 12'h000, ch1: 12'hFFF, exp: 24'hFFF000};
        vecs[2] = '{lead: 4'hA, ch0: 12'h800, ch1: 12'h001, exp: 24'h001800};
        vecs[3] = '{lead: 4'h5, ch0: 12'h123, ch1: 12'h456, exp: 24'h456123};

        rst_n = 1'b0;
        a_start = 0; a_ready = 0; a_ovr_clr = 0; a_din = '0;
        b_start = 0; b_ready = 0; b_ovr_clr = 0; b_din = '0;
        c_start = 0; c_ready = 0; c_ovr_clr = 0; c_din = '0;
        clear_counts();
        repeat (3) @(negedge clk);

        check("reset CS", 64'(a_cs), 64'd1);
        check("reset SCLK", 64'(a_sclk), 64'd1);
        check("reset busy", 64'(a_busy), 64'd0);
        check("reset data_valid", 64'(a_valid), 64'd0);
        check("reset data_out", 64'(a_data), 64'd0);
        check("reset overrun", 64'(a_ovr), 64'd0);
        check("reset conv_complete", 64'(a_cc), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: one capture per vector on the default configuration.
        for (int i = 0; i < 4; i++) begin
            a_frame[0] = {vecs[i].lead, vecs[i].ch0};
            a_frame[1] = {vecs[i].lead, vecs[i].ch1};
            clear_counts();
            do_start(0);
            check($sformatf("v%0d busy after start", i), 64'(a_busy), 64'd1);
            wait_valid(0, 0, n);
            check($sformatf("v%0d latency", i), 64'(n), 64'd71);
            check($sformatf("v%0d data_out", i), 64'(a_data), 64'(vecs[i].exp));
            check($sformatf("v%0d busy at valid", i), 64'(a_busy), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d data held", i), 64'(a_data), 64'(vecs[i].exp));
            check($sformatf("v%0d CS low cycles", i), 64'(a_cslow), 64'd66);
            check($sformatf("v%0d SCLK falls", i), 64'(a_falls), 64'd16);
            check($sformatf("v%0d complete pulses", i), 64'(a_ccn), 64'd1);
            drain_a($sformatf("v%0d", i));
        end

        // Overrun: result pending, second capture must be dropped.
        a_frame[0] = {4'h0, 12'hA5C};
        a_frame[1] = {4'h0, 12'h3F1};
        clear_counts();
        do_start(0);
        wait_valid(0, 0, n);
        a_frame[0] = {4'h0, 12'h111};
        a_frame[1] = {4'h0, 12'h222};
        do_start(0);
        n = 0;
        while (a_busy && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        check("ovr data retained", 64'(a_data), 64'h3F1A5C);
        check("ovr valid held", 64'(a_valid), 64'd1);
        check("ovr flag set", 64'(a_ovr), 64'd1);
        check("ovr one pulse", 64'(a_ccn), 64'd1);
        a_ovr_clr = 1'b1;
        @(negedge clk);
        a_ovr_clr = 1'b0;
        check("ovr cleared", 64'(a_ovr), 64'd0);
        check("ovr valid after clr", 64'(a_valid), 64'd1);
        drain_a("ovr");

        // Start pulsed mid-SHIFT is ignored.
        clear_counts();
        do_start(0);
        repeat (20) @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_valid(0, 21, n);
        check("midstart latency", 64'(n), 64'd71);
        repeat (100) @(negedge clk);
        check("midstart pulses", 64'(a_ccn), 64'd1);
        check("midstart idle", 64'(a_busy), 64'd0);
        drain_a("midstart");

        // Two back-to-back start cycles in IDLE yield one capture.
        clear_counts();
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_start = 1'b0;
        wait_valid(0, 1, n);
        check("b2b latency", 64'(n), 64'd71);
        repeat (100) @(negedge clk);
        check("b2b pulses", 64'(a_ccn), 64'd1);
        check("b2b idle", 64'(a_busy), 64'd0);
        drain_a("b2b");

        // Asynchronous reset mid-SHIFT, then a clean capture.
        a_frame[0] = {4'h0, 12'hFFF};
        a_frame[1] = {4'h0, 12'hFFF};
        clear_counts();
        do_start(0);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst mid CS", 64'(a_cs), 64'd1);
        check("rst mid SCLK", 64'(a_sclk), 64'd1);
        check("rst mid busy", 64'(a_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a_frame[0] = {4'h0, 12'h5A5};
        a_frame[1] = {4'h0, 12'h0F0};
        clear_counts();
        do_start(0);
        wait_valid(0, 0, n);
        check("post-rst latency", 64'(n), 64'd71);
        check("post-rst data_out", 64'(a_data), 64'h0F05A5);
        drain_a("post-rst");

        // Averaging: (100+101+102+104)>>2 = 101.
        b_frame[0] = {4'h0, 12'd100};
        b_frame[1] = {4'h0, 12'd101};
        b_frame[2] = {4'h0, 12'd102};
        b_frame[3] = {4'h0, 12'd104};
        clear_counts();
        do_start(1);
        wait_valid(1, 0, n);
        check("avg latency", 64'(n), 64'd281);
        check("avg data_out", 64'(b_data), 64'd101);
        @(negedge clk);
        check("avg frames", 64'(b_csfalls), 64'd4);
        check("avg CS low cycles", 64'(b_cslow), 64'd264);
        check("avg SCLK falls", 64'(b_falls), 64'd64);
        check("avg pulses", 64'(b_ccn), 64'd1);

        // Four channels, SCLK period of two cycles, junk in lead bits.
        c_frame[0] = {2'b10, 12'h0AB};
        c_frame[1] = {2'b11, 12'hCDE};
        c_frame[2] = {2'b01, 12'h5A5};
        c_frame[3] = {2'b10, 12'hF0F};
        clear_counts();
        do_start(2);
        wait_valid(2, 0, n);
        check("4ch latency", 64'(n), 64'd34);
        check("4ch data_out", 64'(c_data), 64'hF0F5A5CDE0AB);
        @(negedge clk);
        check("4ch CS low cycles", 64'(c_cslow), 64'd29);
        check("4ch SCLK falls", 64'(c_falls), 64'd14);
        check("4ch pulses", 64'(c_ccn), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
